// File: rtl/ntt_pair_feeder_if.sv
// rtl/ntt_pair_feeder_if.sv - issue/write-back bus between the NTT pair feeder and the butterfly datapath
interface ntt_pair_feeder_if #(
  parameter int LOG_N  = 8,
  parameter int ZETA_W = 7
);
  logic              stall_i;
  logic [LOG_N-1:0]  rd_addr1_o;
  logic [LOG_N-1:0]  rd_addr2_o;
  logic [ZETA_W-1:0] zeta_idx_o;
  logic              issue_valid_o;
  logic [LOG_N-1:0]  wr_addr1_o;
  logic [LOG_N-1:0]  wr_addr2_o;
  logic              wr_en_o;

  modport master (
    input  stall_i,
    output rd_addr1_o, rd_addr2_o, zeta_idx_o, issue_valid_o,
    output wr_addr1_o, wr_addr2_o, wr_en_o
  );

  modport slave (
    output stall_i,
    input  rd_addr1_o, rd_addr2_o, zeta_idx_o, issue_valid_o,
    input  wr_addr1_o, wr_addr2_o, wr_en_o
  );
endinterface

// File: rtl/ntt_pair_feeder.sv
// rtl/ntt_pair_feeder.sv - NTT/INTT butterfly pair sequencer with write-back delay line; NTT_FEED_PERF_EN adds perf counters
module ntt_pair_feeder #(
  parameter int LOG_N      = 8,
  parameter int NUM_LAYERS = 7,
  parameter int PIPE_LAT   = 4,
  parameter int ZETA_W     = 7
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               start_i,
  input  logic               inv_i,
  ntt_pair_feeder_if.master  bus,
  output logic [2:0]         layer_o,
  output logic               busy_o,
  output logic               done_o
`ifdef NTT_FEED_PERF_EN
  ,
  output logic [15:0]        perf_cycles_o,
  output logic [15:0]        stall_cnt_o
`endif
);

  // Butterfly index within a layer: N/2 butterflies need LOG_N-1 bits.
  localparam int BW = LOG_N - 1;
  localparam logic [BW-1:0] LAST_B     = '1;
  localparam logic [2:0]    LAST_LAYER = 3'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_LWAIT, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          inv_q, inv_d;
  logic [2:0]    layer_q, layer_d;
  logic [BW-1:0] bfly_q, bfly_d;
  logic          issue;
  logic          drain_busy;

  // Address generation: the pair index j is the butterfly index with a zero
  // bit inserted at position log2(L); the partner simply sets that bit.
  int               lsh;
  logic [LOG_N-1:0] half, mask, bext, j_addr, grp, zeta_full;

  // Write-back delay line, stage PIPE_LAT-1 drives the write port.
  logic             sr_v  [PIPE_LAT];
  logic [LOG_N-1:0] sr_a1 [PIPE_LAT];
  logic [LOG_N-1:0] sr_a2 [PIPE_LAT];

  // Pair addresses and zeta index derived from layer and butterfly index
  always_comb begin
    lsh  = inv_q ? (int'(layer_q) + 1) : (LOG_N - 1 - int'(layer_q));
    half = LOG_N'(1) << lsh;
    mask = half - LOG_N'(1);
    bext = {1'b0, bfly_q};
    j_addr = bext + (bext & ~mask);
    grp  = bext >> lsh;
    if (inv_q) zeta_full = ((LOG_N'(1) << (LOG_N - 1)) >> layer_q) - LOG_N'(1) - grp;
    else       zeta_full = (LOG_N'(1) << layer_q) + grp;
  end

  // Drain is complete once only the output stage (or nothing) still holds data
  always_comb begin
    drain_busy = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) drain_busy = drain_busy | sr_v[i];
  end

  // Next-state and control outputs
  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    layer_d = layer_q;
    bfly_d  = bfly_q;
    issue   = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_ISSUE;
          inv_d   = inv_i;
          layer_d = '0;
          bfly_d  = '0;
        end
      end
      S_ISSUE: begin
        busy_o = 1'b1;
        if (!bus.stall_i) begin
          issue = 1'b1;
          if (bfly_q == LAST_B) begin
            state_d = S_LWAIT;
            bfly_d  = '0;
          end else begin
            bfly_d = bfly_q + BW'(1);
          end
        end
      end
      S_LWAIT: begin
        busy_o = 1'b1;
        if (!drain_busy) begin
          if (layer_q == LAST_LAYER) begin
            state_d = S_DONE;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, latched direction, layer and butterfly counters
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      inv_q   <= 1'b0;
      layer_q <= '0;
      bfly_q  <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      layer_q <= layer_d;
      bfly_q  <= bfly_d;
    end
  end

  // Write-back delay line shifts every cycle, independent of stall
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        sr_v[i]  <= 1'b0;
        sr_a1[i] <= '0;
        sr_a2[i] <= '0;
      end
    end else begin
      sr_v[0]  <= issue;
      sr_a1[0] <= j_addr;
      sr_a2[0] <= j_addr | half;
      for (int i = 1; i < PIPE_LAT; i++) begin
        sr_v[i]  <= sr_v[i-1];
        sr_a1[i] <= sr_a1[i-1];
        sr_a2[i] <= sr_a2[i-1];
      end
    end
  end

  // Read side is only driven while in ISSUE so idle/drain cycles show zeros
  assign bus.issue_valid_o = issue;
  assign bus.rd_addr1_o    = (state_q == S_ISSUE) ? j_addr : '0;
  assign bus.rd_addr2_o    = (state_q == S_ISSUE) ? (j_addr | half) : '0;
  assign bus.zeta_idx_o    = (state_q == S_ISSUE) ? ZETA_W'(zeta_full) : '0;
  assign bus.wr_en_o       = sr_v[PIPE_LAT-1];
  assign bus.wr_addr1_o    = sr_v[PIPE_LAT-1] ? sr_a1[PIPE_LAT-1] : '0;
  assign bus.wr_addr2_o    = sr_v[PIPE_LAT-1] ? sr_a2[PIPE_LAT-1] : '0;
  assign layer_o           = layer_q;

`ifdef NTT_FEED_PERF_EN
  // Busy-cycle and stall-cycle counters, cleared on start and held after done
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      perf_cycles_o <= '0;
      stall_cnt_o   <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      perf_cycles_o <= '0;
      stall_cnt_o   <= '0;
    end else begin
      if (busy_o) perf_cycles_o <= perf_cycles_o + 16'd1;
      if (state_q == S_ISSUE && bus.stall_i) stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
